bcd_seq_tx: RTL and testbench
=============================

Name: bcd_seq_tx

Overview:
Serial transmitter that produces the bit stream consumed by the #68 sequence detector.
- Accepts a packed multi-digit BCD word over a valid/ready handshake.
- Validates every nibble, then shifts the word out MSB-first, one bit per clk, on a single-wire dout.
- Drives an idle line level between frames so the detector stays in its reset state.

Parameters:
DIGITS, 2, number of BCD digits per frame (frame length = 4*DIGITS bits).
IDLE_LEVEL, 1'b1, dout value whenever no data bit is being driven.
GAP_CYCLES, 1, idle cycles forced after each frame before in_ready can rise (0 allowed).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_bcd  input  4*DIGITS  packed BCD word; digit DIGITS-1 in the top nibble
in_valid  input  1  in_bcd is valid this cycle
in_ready  output  1  block accepts in_bcd this cycle
dout  output  1  serial data, MSB first
dout_valid  output  1  dout carries a frame bit this cycle
frame_done  output  1  one-cycle pulse coincident with the last frame bit
err  output  1  one-cycle pulse: rejected word (some nibble > 9)

Behaviour:
- Reset values (async, immediate): state IDLE, dout=IDLE_LEVEL, dout_valid=0, frame_done=0, err=0, in_ready=0 while reset is high. Shift register and counters are cleared.
- in_ready = (state==IDLE) and not reset. A transfer occurs on a clk edge with in_valid && in_ready.
- States:
  - IDLE: on transfer with all nibbles <= 9, load the shift register and go to SHIFT. On transfer with any nibble > 9, pulse err for the next cycle, stay in IDLE, transmit nothing. Otherwise stay.
  - SHIFT: dout = shreg MSB, dout_valid=1. Shift left each cycle. Bit counter runs 0..4*DIGITS-1. On the last bit, frame_done=1; next state is GAP if GAP_CYCLES>0, else IDLE.
  - GAP: dout=IDLE_LEVEL, dout_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
- Latency:
  - Transfer at edge T: first bit on dout in cycle T+1, last bit at T+4*DIGITS.
  - in_ready rises at T+4*DIGITS+GAP_CYCLES+1.
  - All outputs are registered; no combinational path from in_* to dout.
- in_bcd is sampled only at the transfer edge; later input changes have no effect on a frame in flight.
- in_valid while busy is ignored; no queuing.
- Reset mid-frame aborts the frame: line returns to IDLE_LEVEL at once, no frame_done.
- Counter width is $clog2(4*DIGITS+1) and must not overflow. GAP counter width is $clog2(GAP_CYCLES+1), minimum 1.

Optional Feature:
BCD_SEQ_TX_PARITY_EN
- Defined: one even-parity bit (XOR of all data bits) is appended after the LSB. dout_valid is high for 4*DIGITS+1 cycles, and frame_done moves to the parity-bit cycle.
- Undefined: no parity bit; the frame is exactly 4*DIGITS bits.

Decomposition:
- Shared package bcd_seq_pkg holds:
  - state enum type tx_state_t {TX_IDLE, TX_SHIFT, TX_GAP}
  - constant NIBBLE_MAX = 4'd9
  - function bcd_word_ok(): returns 1 when every nibble is <= 9; shared with the detector bench scoreboard.
- One sub-module, bcd_nibble_check: combinational per-word validity, parameterised by DIGITS, instantiated once in the IDLE path.

Test Plan:
- Nominal 0x68: DIGITS=2, transfer at T -> dout = 0,1,1,0,1,0,0,0 in T+1..T+8; dout_valid high 8 cycles; frame_done at T+8; dout=1 at T+9; in_ready=1 at T+10.
- Invalid 0x6A: transfer -> err pulse at T+1, dout_valid stays 0, dout=1 throughout, in_ready stays 1.
- Back-to-back 0x68 then 0x12 (in_valid held high, GAP_CYCLES=1) -> second frame bits 0,0,0,1,0,0,1,0 start at T+11; exactly one idle-1 cycle between frames.
- Reset asserted asynchronously mid-cycle during bit 3 of 0x68 -> dout=1 and dout_valid=0 without waiting for clk; no frame_done; a 0x35 sent after release transmits correctly.
- Loopback into the #68 sequence detector: send 0x12, 0x68, 0x86 -> detector dout pulses only for 0x68, at its 9th bit time.
- Parity build (macro defined): 0x68 -> 9 valid bits, ninth bit = 1, frame_done on ninth bit; 0x33 -> ninth bit = 0.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// bcd_seq_pkg: definitions shared by the BCD serial transmitter and the
// sequence-detector scoreboard.
//   tx_state_t   transmitter FSM states
//   NIBBLE_MAX   largest legal BCD digit
//   bcd_word_ok  1 when every one of the low 'digits' nibbles is <= 9
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_t;

  localparam logic [3:0] NIBBLE_MAX = 4'd9;

  // Widest word bcd_word_ok can inspect; narrower words are zero-extended.
  localparam int MAX_DIGITS = 16;

  function automatic logic bcd_word_ok(input logic [4*MAX_DIGITS-1:0] word,
                                       input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && word[4*i +: 4] > NIBBLE_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_seq_tx_nibble_check.sv
// bcd_nibble_check: combinational validity check of a packed BCD word.
// Parameters:
//   DIGITS  number of nibbles in word
// Ports:
//   word  input   packed BCD word, digit DIGITS-1 in the top nibble
//   ok    output  1 when every nibble is <= 9
module bcd_nibble_check
  import bcd_seq_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] word,
  output logic                ok
);

  always_comb begin
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (word[4*i +: 4] > NIBBLE_MAX) ok = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_seq_tx.sv
// bcd_seq_tx: serial transmitter for packed BCD words.
// A word accepted over in_valid/in_ready is checked digit by digit; a legal
// word is shifted out MSB-first, one bit per clk, on dout. An illegal word
// produces a one-cycle err pulse and nothing is transmitted. Between frames
// dout rests at IDLE_LEVEL, and GAP_CYCLES idle cycles follow every frame.
//
// Optional build macro BCD_SEQ_TX_PARITY_EN: appends one even-parity bit
// (XOR of all data bits) after the LSB; frame_done then marks the parity bit.
//
// Parameters:
//   DIGITS      BCD digits per frame (4*DIGITS data bits)
//   IDLE_LEVEL  dout level when no frame bit is driven
//   GAP_CYCLES  idle cycles after each frame before in_ready returns (>= 0)
// Ports:
//   clk         clock
//   reset       asynchronous, active-high reset
//   in_bcd      packed BCD word, digit DIGITS-1 in the top nibble
//   in_valid    in_bcd valid this cycle
//   in_ready    block accepts in_bcd this cycle
//   dout        serial data, MSB first (registered)
//   dout_valid  dout carries a frame bit (registered)
//   frame_done  pulse with the last frame bit (registered)
//   err         pulse the cycle after an illegal word is taken (registered)
module bcd_seq_tx
  import bcd_seq_pkg::*;
#(
  parameter int   DIGITS     = 2,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] in_bcd,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                dout,
  output logic                dout_valid,
  output logic                frame_done,
  output logic                err
);

  localparam int DATA_W = 4 * DIGITS;
`ifdef BCD_SEQ_TX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  // Bit index never exceeds FRAME_W-1 <= 4*DIGITS, so this width suffices
  // with or without the parity bit.
  localparam int BW = $clog2(4 * DIGITS + 1);
  localparam int GW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t          state;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] shreg;
  logic [BW-1:0]      bcnt;
  logic [GW-1:0]      gcnt;
  logic               word_ok;

  bcd_nibble_check #(
    .DIGITS(DIGITS)
  ) u_check (
    .word(in_bcd),
    .ok  (word_ok)
  );

  // The parity bit rides in the shift register's LSB so data and parity
  // leave through the same path.
`ifdef BCD_SEQ_TX_PARITY_EN
  assign frame = {in_bcd, ^in_bcd};
`else
  assign frame = in_bcd;
`endif

  assign in_ready = (state == TX_IDLE) && !reset;

  // shreg holds the bits still to be sent after the one currently on dout;
  // loading puts the MSB straight onto dout so bit 0 appears one cycle
  // after the transfer edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= TX_IDLE;
      shreg      <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (in_valid) begin
            if (word_ok) begin
              dout       <= frame[FRAME_W-1];
              shreg      <= {frame[FRAME_W-2:0], 1'b0};
              bcnt       <= '0;
              dout_valid <= 1'b1;
              frame_done <= 1'b0;
              state      <= TX_SHIFT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        TX_SHIFT: begin
          if (bcnt == BIT_LAST) begin
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
            bcnt       <= '0;
            if (GAP_CYCLES > 0) begin
              gcnt  <= '0;
              state <= TX_GAP;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            dout       <= shreg[FRAME_W-1];
            shreg      <= {shreg[FRAME_W-2:0], 1'b0};
            bcnt       <= bcnt + 1'b1;
            frame_done <= ((bcnt + 1'b1) == BIT_LAST);
          end
        end
        TX_GAP: begin
          if (gcnt == GAP_LAST) state <= TX_IDLE;
          else                  gcnt  <= gcnt + 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_tx.sv
// tb_bcd_seq_tx: self-checking bench for bcd_seq_tx (DIGITS=2, GAP_CYCLES=1).
// A cycle-level model derived from the frame timing rules predicts every
// output on every falling edge; directed scenarios add literal expectations.
module tb_bcd_seq_tx;

  localparam int   DIGITS = 2;
  localparam int   GAP    = 1;
  localparam logic IDLE   = 1'b1;
`ifdef BCD_SEQ_TX_PARITY_EN
  localparam int FL = 4 * DIGITS + 1;
`else
  localparam int FL = 4 * DIGITS;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] in_bcd   = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, dout, dout_valid, frame_done, err;

  bcd_seq_tx #(
    .DIGITS    (DIGITS),
    .IDLE_LEVEL(IDLE),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_bcd    (in_bcd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .frame_done(frame_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          cyc      = 0;
  int          fs       = -1000;  // cycle carrying the first bit of the current frame
  int          ready_at = 0;      // first cycle in_ready may be high
  int          err_at   = -1;
  int          last_t   = -1;
  logic [15:0] fword    = '0;

  function automatic logic word_ok(input logic [7:0] w);
    return ((w / 16) <= 9) && ((w % 16) <= 9);
  endfunction

  function automatic logic [15:0] frame_of(input logic [7:0] w);
`ifdef BCD_SEQ_TX_PARITY_EN
    return {7'd0, w, ^w};
`else
    return {8'd0, w};
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset && in_valid && cyc >= ready_at) begin
      last_t = cyc;
      if (word_ok(in_bcd)) begin
        fs       = cyc + 1;
        fword    = frame_of(in_bcd);
        ready_at = cyc + 1 + FL + GAP;
      end else begin
        err_at = cyc + 1;
      end
    end
    cyc++;
  end

  always @(posedge reset) begin
    fs       = -1000;
    ready_at = 0;
    err_at   = -1;
  end

  always @(negedge clk) begin
    logic active;
    logic exp_d;
    active = (fs >= 0) && (cyc >= fs) && (cyc < fs + FL);
    exp_d  = active ? fword[FL-1-(cyc-fs)] : IDLE;
    chk("in_ready",   {31'd0, in_ready},   {31'd0, (!reset && cyc >= ready_at)});
    chk("dout",       {31'd0, dout},       {31'd0, exp_d});
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, active});
    chk("frame_done", {31'd0, frame_done}, {31'd0, (active && cyc == fs + FL - 1)});
    chk("err",        {31'd0, err},        {31'd0, (!reset && cyc == err_at)});
  end

  // Line-level #68 detector: window over everything on dout.
  logic [7:0] win     = 8'hFF;
  int         hits    = 0;
  int         hit_bad = 0;
  always @(negedge clk) begin
    if (reset) win = 8'hFF;
    else begin
      win = {win[6:0], dout};
      if (win == 8'h68) begin
        hits++;
        if (!frame_done) hit_bad++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // One transfer, then observe FL+GAP+2 cycles (index 1 = cycle after edge).
  task automatic send_capture(input logic [7:0] w, output logic [15:0] bits,
                              output int nbits, output int fd_at,
                              output int rdy_at, output int er_at);
    wait_ready();
    in_bcd   = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_bcd = ~w;  // late changes must not affect the frame
    bits = '0; nbits = 0; fd_at = -1; rdy_at = -1; er_at = -1;
    for (int i = 1; i <= FL + GAP + 2; i++) begin
      @(negedge clk);
      if (dout_valid) begin
        bits = {bits[14:0], dout};
        nbits++;
      end
      if (frame_done && fd_at < 0) fd_at = i;
      if (in_ready && rdy_at < 0) rdy_at = i;
      if (err && er_at < 0) er_at = i;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int nbits, fd_at, rdy_at, er_at;
    logic [7:0] vec [9];
    logic       vok [9];
    int start2, n2, fd_cnt, base_hits, base_bad;
    logic [15:0] bits2;
    logic prev_dv;

    vec = '{8'h00, 8'h99, 8'h90, 8'h09, 8'hA0, 8'h0A, 8'h9A, 8'h45, 8'hFF};
    vok = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Nominal 0x68
    send_capture(8'h68, bits, nbits, fd_at, rdy_at, er_at);
`ifdef BCD_SEQ_TX_PARITY_EN
    chk("nom_bits", {16'd0, bits}, 32'h0D1);
    chk("nom_nbits", nbits, 9);
    chk("nom_fd_at", fd_at, 9);
    chk("nom_rdy_at", rdy_at, 11);
`else
    chk("nom_bits", {16'd0, bits}, 32'h068);
    chk("nom_nbits", nbits, 8);
    chk("nom_fd_at", fd_at, 8);
    chk("nom_rdy_at", rdy_at, 10);
`endif
    chk("nom_err", er_at, -1);

    // Invalid 0x6A
    send_capture(8'h6A, bits, nbits, fd_at, rdy_at, er_at);
    chk("inv_nbits", nbits, 0);
    chk("inv_err_at", er_at, 1);
    chk("inv_rdy_at", rdy_at, 1);
    chk("inv_fd", fd_at, -1);

    // Boundary digits and illegal nibbles
    for (int k = 0; k < 9; k++) begin
      send_capture(vec[k], bits, nbits, fd_at, rdy_at, er_at);
      chk("vec_nbits", nbits, vok[k] ? FL : 0);
      chk("vec_err_at", er_at, vok[k] ? -1 : 1);
      if (vok[k]) chk("vec_bits", {16'd0, bits}, {16'd0, frame_of(vec[k])});
    end

    // Back-to-back 0x68 then 0x12 with in_valid held
    wait_ready();
    in_bcd   = 8'h68;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_bcd = 8'h12;
    start2 = -1; n2 = 0; bits2 = '0; prev_dv = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i > 1 && dout_valid && !prev_dv && start2 < 0) start2 = i;
      if (start2 > 0 && dout_valid) begin
        bits2 = {bits2[14:0], dout};
        n2++;
      end
      prev_dv = dout_valid;
      if (i == 12) in_valid = 1'b0;
    end
    chk("b2b_start", start2, FL + GAP + 2);
    chk("b2b_bits", {16'd0, bits2}, {16'd0, frame_of(8'h12)});
    chk("b2b_nbits", n2, FL);

    // Asynchronous reset during bit 3 of 0x68
    wait_ready();
    in_bcd   = 8'h68;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_dout", {31'd0, dout}, {31'd0, IDLE});
    chk("rst_dv", {31'd0, dout_valid}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    fd_cnt = 0;
    for (int i = 0; i < FL + 2; i++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    chk("rst_no_fd", fd_cnt, 0);
    send_capture(8'h35, bits, nbits, fd_at, rdy_at, er_at);
    chk("post_rst_bits", {16'd0, bits}, {16'd0, frame_of(8'h35)});
    chk("post_rst_nbits", nbits, FL);

`ifdef BCD_SEQ_TX_PARITY_EN
    send_capture(8'h33, bits, nbits, fd_at, rdy_at, er_at);
    chk("par33_bits", {16'd0, bits}, 32'h066);
    chk("par33_fd_at", fd_at, 9);
`else
    // Loopback into a #68 detector
    base_hits = hits;
    base_bad  = hit_bad;
    send_capture(8'h12, bits, nbits, fd_at, rdy_at, er_at);
    send_capture(8'h68, bits, nbits, fd_at, rdy_at, er_at);
    send_capture(8'h86, bits, nbits, fd_at, rdy_at, er_at);
    chk("loop_hits", hits - base_hits, 1);
    chk("loop_hit_on_last_bit", hit_bad - base_bad, 0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
